// File: rtl/systolic_pkg.sv
// Shared definitions for the 2x2 FP16 systolic array controller.
//   FP16_W / FP16_ZERO : element width and the +0 pattern used for every idle drive
//   ARRAY_LAT_DEF      : default cycles from left1(x0) to down1(Y0) of the same row
//   PE11..PE22         : bit positions of each PE in the internal we/mux vectors
//   ctrl_state_t       : controller FSM states
package systolic_pkg;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

    localparam int ARRAY_LAT_DEF = 2;

    localparam int PE11   = 0;
    localparam int PE12   = 1;
    localparam int PE21   = 2;
    localparam int PE22   = 3;
    localparam int NUM_PE = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD0  = 3'd1,
        LOAD1  = 3'd2,
        STREAM = 3'd3,
        DRAIN  = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/systolic_deskew.sv
// Result capture for the systolic array: realigns the two column outputs of one
// activation row into a single result row.
//   clk, reset  : clock, synchronous active-high reset
//   row_issue   : a real activation row entered the array this cycle
//   down1/down2 : array column outputs (column 2 lags column 1 by one cycle)
//   y_valid     : registered; one pulse per issued row, in issue order
//   y_data      : {Y0, Y1}; zero when y_valid is low
module systolic_deskew
    import systolic_pkg::*;
#(
    parameter int DW        = FP16_W,
    parameter int ARRAY_LAT = ARRAY_LAT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            row_issue,
    input  logic [DW-1:0]   down1,
    input  logic [DW-1:0]   down2,
    output logic            y_valid,
    output logic [2*DW-1:0] y_data
);

    // vld_q[k] set: a real row was issued k+1 cycles ago. Bubbles shift in zeros,
    // so they never produce a result.
    logic [ARRAY_LAT:0] vld_q, vld_d;
    logic [DW-1:0]      hold_q, hold_d;
    logic               y_valid_q, y_valid_d;
    logic [2*DW-1:0]    y_data_q, y_data_d;

    always_comb begin
        vld_d     = {vld_q[ARRAY_LAT-1:0], row_issue};
        hold_d    = hold_q;
        y_valid_d = 1'b0;
        y_data_d  = '0;

        // Column 1 result is on down1 ARRAY_LAT cycles after issue.
        if (vld_q[ARRAY_LAT-1]) begin
            hold_d = down1;
        end

        // One cycle later column 2 arrives; pair it with the held column 1.
        if (vld_q[ARRAY_LAT]) begin
            y_valid_d = 1'b1;
            y_data_d  = {hold_q, down2};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q     <= '0;
            hold_q    <= '0;
            y_valid_q <= 1'b0;
            y_data_q  <= '0;
        end else begin
            vld_q     <= vld_d;
            hold_q    <= hold_d;
            y_valid_q <= y_valid_d;
            y_data_q  <= y_data_d;
        end
    end

    assign y_valid = y_valid_q;
    assign y_data  = y_data_q;

endmodule

// File: rtl/systolic_array_ctrl.sv
// Host-side controller for the 2x2 FP16 systolic array.
// Loads a weight matrix once per job, streams activation rows with the one-cycle
// row-2 skew the array needs, and returns whole result rows Y[r] = X[r]*W.
//
// Handshakes: a transfer happens in a cycle where valid and ready are both high
// at the rising edge. Producers hold data stable while valid is high and not yet
// accepted; ready never depends on valid. y_valid has no ready: the sink must
// accept every result row in the cycle it is presented.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   w_valid/w_ready     : weight job {w11,w12,w21,w22} on w_data (w11 in msbs)
//   x_valid/x_ready     : activation row {x0,x1} on x_data (x0 in msbs); x_last ends job
//   y_valid/y_data      : result row {Y0,Y1}
//   done                : one-cycle pulse after the last result row of a job
//   top1/top2           : weight inputs to array columns
//   left1/left2         : activation inputs to array rows
//   we1..we4, mux1..mux4: per-PE weight latch / compute select (PE11,PE12,PE21,PE22)
//   down1/down2         : array column outputs
//   state_dbg           : current FSM state (ctrl_state_t encoding)
module systolic_array_ctrl
    import systolic_pkg::*;
#(
    parameter int DW        = FP16_W,
    parameter int ARRAY_LAT = ARRAY_LAT_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            w_valid,
    output logic            w_ready,
    input  logic [4*DW-1:0] w_data,
    input  logic            x_valid,
    output logic            x_ready,
    input  logic [2*DW-1:0] x_data,
    input  logic            x_last,
    output logic            y_valid,
    output logic [2*DW-1:0] y_data,
    output logic            done,
    output logic [DW-1:0]   top1,
    output logic [DW-1:0]   top2,
    output logic [DW-1:0]   left1,
    output logic [DW-1:0]   left2,
    output logic            we1,
    output logic            we2,
    output logic            we3,
    output logic            we4,
    output logic            mux1,
    output logic            mux2,
    output logic            mux3,
    output logic            mux4,
    input  logic [DW-1:0]   down1,
    input  logic [DW-1:0]   down2,
    output logic [2:0]      state_dbg
);

    localparam logic [DW-1:0] ZERO = DW'(FP16_ZERO);

    // DRAIN keeps the array computing until the last row has left the deskew regs.
    localparam int DRAIN_CYCLES = ARRAY_LAT + 2;
    localparam int CNT_W        = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

    ctrl_state_t       state_q, state_d;
    logic [4*DW-1:0]   w_q, w_d;
    logic [DW-1:0]     x1_skew_q, x1_skew_d;
    logic              mux24_q, mux24_d;
    logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic              done_q, done_d;

    logic [NUM_PE-1:0] we_vec;
    logic [NUM_PE-1:0] mux_vec;
    logic              w_hs;
    logic              x_hs;

    logic [DW-1:0] w11, w12, w21, w22;
    logic [DW-1:0] x0_in, x1_in;

    assign w11   = w_q[4*DW-1 -: DW];
    assign w12   = w_q[3*DW-1 -: DW];
    assign w21   = w_q[2*DW-1 -: DW];
    assign w22   = w_q[DW-1:0];
    assign x0_in = x_data[2*DW-1 -: DW];
    assign x1_in = x_data[DW-1:0];

    assign w_hs = w_valid & w_ready;
    assign x_hs = x_valid & x_ready;

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        x1_skew_d   = ZERO;
        mux24_d     = 1'b0;
        drain_cnt_d = '0;
        done_d      = 1'b0;

        w_ready = 1'b0;
        x_ready = 1'b0;
        top1    = ZERO;
        top2    = ZERO;
        left1   = ZERO;
        left2   = ZERO;
        we_vec  = '0;
        mux_vec = '0;

        unique case (state_q)
            IDLE: begin
                // Held low during reset so every output reads 0 while reset is up.
                w_ready = ~reset;
                if (w_hs) begin
                    w_d     = w_data;
                    state_d = LOAD0;
                end
            end

            // Row-2 weights go out first; they ride the column pass-through
            // registers so they sit at PE21/PE22 when LOAD1 pulses we.
            LOAD0: begin
                top1    = w21;
                top2    = w22;
                state_d = LOAD1;
            end

            LOAD1: begin
                top1    = w11;
                top2    = w12;
                we_vec  = '1;
                state_d = STREAM;
            end

            STREAM: begin
                x_ready        = 1'b1;
                left2          = x1_skew_q;
                mux_vec[PE11]  = 1'b1;
                mux_vec[PE21]  = 1'b1;
                // Column 2 sees its first activation one cycle after column 1.
                mux_vec[PE12]  = mux24_q;
                mux_vec[PE22]  = mux24_q;
                mux24_d        = 1'b1;
                if (x_hs) begin
                    left1     = x0_in;
                    x1_skew_d = x1_in;
                    if (x_last) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                left2       = x1_skew_q;
                mux_vec     = '1;
                mux24_d     = 1'b1;
                drain_cnt_d = drain_cnt_q + 1'b1;
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    drain_cnt_d = '0;
                    mux24_d     = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            w_q         <= '0;
            x1_skew_q   <= ZERO;
            mux24_q     <= 1'b0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            x1_skew_q   <= x1_skew_d;
            mux24_q     <= mux24_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    systolic_deskew #(
        .DW        (DW),
        .ARRAY_LAT (ARRAY_LAT)
    ) u_deskew (
        .clk       (clk),
        .reset     (reset),
        .row_issue (x_hs),
        .down1     (down1),
        .down2     (down2),
        .y_valid   (y_valid),
        .y_data    (y_data)
    );

    assign we1  = we_vec[PE11];
    assign we2  = we_vec[PE12];
    assign we3  = we_vec[PE21];
    assign we4  = we_vec[PE22];
    assign mux1 = mux_vec[PE11];
    assign mux2 = mux_vec[PE12];
    assign mux3 = mux_vec[PE21];
    assign mux4 = mux_vec[PE22];

    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Bench for systolic_array_ctrl. A small behavioural 2x2 array (integer
// multiply-accumulate, 16-bit wrap) stands in for the FP16 array so results are
// exact; the reference model is the plain matrix product X[r]*W.
module tb_systolic_array_ctrl;
    import systolic_pkg::*;

    localparam int DW  = 16;
    localparam int LAT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic            w_valid, w_ready, x_valid, x_ready, x_last, y_valid, done;
    logic [4*DW-1:0] w_data;
    logic [2*DW-1:0] x_data, y_data;
    logic [DW-1:0]   top1, top2, left1, left2, down1, down2;
    logic            we1, we2, we3, we4, mux1, mux2, mux3, mux4;
    logic [2:0]      state_dbg;

    systolic_array_ctrl #(.DW(DW), .ARRAY_LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
        .y_valid(y_valid), .y_data(y_data), .done(done),
        .top1(top1), .top2(top2), .left1(left1), .left2(left2),
        .we1(we1), .we2(we2), .we3(we3), .we4(we4),
        .mux1(mux1), .mux2(mux2), .mux3(mux3), .mux4(mux4),
        .down1(down1), .down2(down2), .state_dbg(state_dbg)
    );

    // ---------------- array stand-in ----------------
    logic [DW-1:0] t1_q = '0, t2_q = '0;
    logic [DW-1:0] wt11_q = '0, wt12_q = '0, wt21_q = '0, wt22_q = '0;
    logic [DW-1:0] a11_q = '0, a21_q = '0;
    logic [DW-1:0] p11_q = '0, p12_q = '0, p21_q = '0, p22_q = '0;

    always @(posedge clk) begin
        t1_q <= top1;
        t2_q <= top2;
        if (we1) wt11_q <= top1;
        if (we2) wt12_q <= top2;
        if (we3) wt21_q <= t1_q;
        if (we4) wt22_q <= t2_q;
        a11_q <= left1;
        a21_q <= left2;
        p11_q <= mux1 ? left1 * wt11_q : '0;
        p12_q <= mux2 ? a11_q * wt12_q : '0;
        p21_q <= mux3 ? p11_q + left2 * wt21_q : '0;
        p22_q <= mux4 ? p12_q + a21_q * wt22_q : '0;
    end
    assign down1 = p21_q;
    assign down2 = p22_q;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [2*DW-1:0] exp_q[$];
    int              exp_cyc_q[$];
    logic [4*DW-1:0] cur_w = '0;
    bit              done_pending = 1'b0;
    int              done_count = 0;
    int              last_y_cyc = -10;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Y[r] = X[r] * W with W = [[w11,w12],[w21,w22]]
    function automatic logic [2*DW-1:0] ref_row(input logic [4*DW-1:0] w, input logic [2*DW-1:0] x);
        logic [DW-1:0] w11, w12, w21, w22, x0, x1, y0, y1;
        {w11, w12, w21, w22} = w;
        {x0, x1} = x;
        y0 = x0 * w11 + x1 * w21;
        y1 = x0 * w12 + x1 * w22;
        return {y0, y1};
    endfunction

    // ---------------- monitor ----------------
    logic            mon_hs;
    logic            prev_hs = 1'b0, prev_last = 1'b0;
    logic [DW-1:0]   prev_x1 = '0;
    logic [4*DW-1:0] load_w = '0;
    int              since_w = 0;
    logic [2*DW-1:0] e_row;
    int              e_cyc;

    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            exp_cyc_q.delete();
            done_pending = 1'b0;
            since_w = 0;
            prev_hs = 1'b0;
            prev_last = 1'b0;
            prev_x1 = '0;
        end else begin
            mon_hs = x_valid && x_ready;
            check("left1", 64'(left1), mon_hs ? 64'(x_data[2*DW-1 -: DW]) : 64'd0);
            check("left2", 64'(left2), prev_hs ? 64'(prev_x1) : 64'd0);
            if (prev_hs && prev_last) check("x_ready_after_last", 64'(x_ready), 64'd0);
            prev_hs = mon_hs;
            prev_last = x_last;
            prev_x1 = x_data[DW-1:0];

            if (y_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL y_unexpected: got y_data %h expected no row (cycle %0d)", y_data, cyc);
                end else begin
                    e_row = exp_q.pop_front();
                    e_cyc = exp_cyc_q.pop_front();
                    check("y_data", 64'(y_data), 64'(e_row));
                    check("y_cycle", 64'(cyc), 64'(e_cyc));
                end
                last_y_cyc = cyc;
            end

            if (done) begin
                check("done_expected", 64'(done_pending), 64'd1);
                check("done_after_last_y", 64'(cyc), 64'(last_y_cyc + 1));
                check("done_rows_left", 64'(exp_q.size()), 64'd0);
                check("done_mux_off", 64'({mux1, mux2, mux3, mux4}), 64'd0);
                check("done_state", 64'(state_dbg), 64'(IDLE));
                done_pending = 1'b0;
                done_count++;
            end

            case (since_w)
                1: begin
                    check("load0_top", 64'({top1, top2}), 64'({load_w[2*DW-1 -: DW], load_w[DW-1:0]}));
                    check("load0_we", 64'({we1, we2, we3, we4}), 64'd0);
                    check("load0_rdy", 64'({w_ready, x_ready}), 64'd0);
                    check("load0_state", 64'(state_dbg), 64'(LOAD0));
                end
                2: begin
                    check("load1_top", 64'({top1, top2}), 64'({load_w[4*DW-1 -: DW], load_w[3*DW-1 -: DW]}));
                    check("load1_we", 64'({we1, we2, we3, we4}), 64'hF);
                    check("load1_mux", 64'({mux1, mux2, mux3, mux4}), 64'd0);
                    check("load1_rdy", 64'({w_ready, x_ready}), 64'd0);
                end
                3: begin
                    check("stream0_mux", 64'({mux1, mux2, mux3, mux4}), 64'b1010);
                    check("stream0_we_top", 64'({we1, we2, we3, we4, top1, top2}), 64'd0);
                    check("stream0_state", 64'(state_dbg), 64'(STREAM));
                end
                4: check("stream1_mux", 64'({mux1, mux2, mux3, mux4}), 64'b1111);
                default: ;
            endcase
            if (w_valid && w_ready) begin
                since_w = 1;
                load_w = w_data;
            end else if (since_w > 0 && since_w < 4) begin
                since_w++;
            end else begin
                since_w = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    logic [2*DW-1:0] job_x[8];
    int              job_gap[8];

    task automatic load_weights(input logic [4*DW-1:0] w);
        int n = 0;
        w_valid = 1'b1;
        w_data = w;
        forever begin
            @(negedge clk);
            if (w_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL w_ready_timeout: got no w_ready expected w_ready within 200 cycles");
                break;
            end
        end
        cur_w = w;
        @(posedge clk);
        #1;
        w_valid = 1'b0;
        w_data = {$urandom, $urandom};
    endtask

    task automatic send_x(input logic [2*DW-1:0] d, input bit last, input bit hold_w);
        int n = 0;
        x_valid = 1'b1;
        x_data = d;
        x_last = last;
        if (hold_w) begin
            w_valid = 1'b1;
            w_data = {$urandom, $urandom};
        end
        forever begin
            @(negedge clk);
            if (x_ready) begin
                exp_q.push_back(ref_row(cur_w, d));
                exp_cyc_q.push_back(cyc + LAT + 2);
                if (last) done_pending = 1'b1;
                if (hold_w) check("w_ready_in_stream", 64'(w_ready), 64'd0);
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL x_ready_timeout: got no x_ready expected x_ready within 200 cycles");
                break;
            end
        end
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        x_last = 1'b0;
        x_data = $urandom;
        w_valid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done();
        int n = 0;
        while (done_pending && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (done_pending) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 100 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input logic [4*DW-1:0] w, input int n, input bit hold_w);
        load_weights(w);
        for (int i = 0; i < n; i++) begin
            send_x(job_x[i], i == n - 1, hold_w && i == 0);
            if (i < n - 1) idle_cycles(job_gap[i]);
        end
        wait_done();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ctrl"}, 64'({w_ready, x_ready, y_valid, done, we1, we2, we3, we4,
                                  mux1, mux2, mux3, mux4}), 64'd0);
        check({tag, "_y"}, 64'(y_data), 64'd0);
        check({tag, "_top"}, 64'({top1, top2}), 64'd0);
        check({tag, "_left"}, 64'({left1, left2}), 64'd0);
        check({tag, "_state"}, 64'(state_dbg), 64'(IDLE));
    endtask

    localparam logic [4*DW-1:0] W_DIR = {16'h2E66, 16'h3266, 16'h34CD, 16'h3666};

    // ---------------- main sequence ----------------
    int dc;
    initial begin
        w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0; x_last = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1 reset = 1'b0;
        idle_cycles(2);

        // two rows back to back
        job_x[0] = {16'h3800, 16'h38CD}; job_x[1] = {16'h399A, 16'h3A66};
        job_gap[0] = 0;
        run_job(W_DIR, 2, 1'b0);

        // two bubbles between rows
        job_gap[0] = 2;
        run_job(W_DIR, 2, 1'b0);

        // single-row job, then a fresh job with new weights
        run_job(W_DIR, 1, 1'b0);
        job_x[0] = 32'h1234_0007; job_x[1] = 32'h0003_8001; job_x[2] = 32'hFFFF_0101;
        job_gap[0] = 1; job_gap[1] = 0;
        run_job({16'h0002, 16'h0005, 16'hFFFE, 16'h1001}, 3, 1'b0);

        // w_valid held during STREAM
        job_x[0] = $urandom; job_x[1] = $urandom; job_gap[0] = 0;
        run_job({$urandom, $urandom}, 2, 1'b1);

        // randomized jobs
        for (int j = 0; j < 10; j++) begin
            int nr;
            nr = $urandom_range(1, 6);
            for (int i = 0; i < nr; i++) begin
                job_x[i] = $urandom;
                job_gap[i] = $urandom_range(0, 2);
            end
            run_job({$urandom, $urandom}, nr, 1'($urandom_range(0, 1)));
            idle_cycles($urandom_range(0, 3));
        end

        // reset in the middle of STREAM
        dc = done_count;
        load_weights({$urandom, $urandom});
        send_x($urandom, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(posedge clk);
        #1 reset = 1'b0;
        idle_cycles(12);
        check("no_done_after_reset", 64'(done_count), 64'(dc));

        // controller still usable afterwards
        job_x[0] = $urandom; job_x[1] = $urandom; job_gap[0] = 1;
        run_job({$urandom, $urandom}, 2, 1'b0);
        idle_cycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected finish before 400000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
